fp_add_seq: RTL and testbench
=============================

Name: fp_add_seq

Overview:
- Multi-cycle sequencer for the minifloat adder path. It accepts two operands over a valid/ready handshake.
- It drives the exponent subtraction and orders the operands so the larger magnitude comes first.
- It then runs the alignment shifts, the mantissa add/subtract, and the normalisation shifts, one shift per cycle.
- The result is returned over a valid/ready handshake. The block sits between the operand register file and the result writeback in the floating-point unit.

Parameters:
- EXP_W, 3, exponent field width. The exponent difference is computed as an (EXP_W+1)-bit two's-complement value, a - b with carry-in 1.
- MAN_W, 4, stored fraction width. The significand is MAN_W+1 bits, with the hidden 1 present whenever exp != 0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- op_a  in  1+EXP_W+MAN_W  operand A, fields {sign, exp, frac}
- op_b  in  1+EXP_W+MAN_W  operand B, same format
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  1+EXP_W+MAN_W  sum, same format
- busy  out  1  high in every state except IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - Reset drives state to IDLE, in_ready=1, out_valid=0, result=0, busy=0.
  - Reset asserted mid-operation aborts the operation; no result is produced.
- Number format:
  - exp==0 means zero; there are no denormals, inf or NaN.
  - exp==2^EXP_W-1 is an ordinary normal value.
- FSM states: IDLE, EXP, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, op_a/op_b are captured and the state goes to EXP.
  - in_ready is 0 in all other states.
- EXP (1 cycle):
  - If one operand has exp==0, result = the other operand (+0 if both are zero) and the state goes straight to DONE.
  - Otherwise compute d = e_a - e_b.
  - Swap so that "big" = operand with the larger {exp,frac}. A tie keeps A as big.
  - Load the shift count with |d| and the significands with {1,frac}.
  - Next state: ALIGN if |d|>0, else ADD.
- ALIGN (exactly |d| cycles):
  - Each cycle the small significand shifts right by 1 and the count decrements. Bits shifted out are discarded (truncation).
  - When |d| >= MAN_W+1 the significand reaches 0 and the state still occupies |d| cycles.
  - Exit to ADD when the count is 0.
- ADD (1 cycle):
  - Equal signs: sum = big + small, (MAN_W+2) bits.
  - Unequal signs: sum = big - small, which is never negative.
  - Result sign = sign of big.
  - If sum==0, result = 0 (all bits, +0) and the state goes to DONE.
  - If sum[MSB] is set or sum[MAN_W]==0, go to NORM; otherwise go to DONE.
- NORM (one cycle per shift):
  - Carry case: if sum[MAN_W+1]=1, shift right 1 and exp+1 (one cycle).
    - If exp would exceed 2^EXP_W-1, saturate to {sign, all-ones exp, all-ones frac}, then go to DONE.
  - Left-normalise case: else while sum[MAN_W]==0, shift left 1 and exp-1 per cycle.
    - If exp reaches 0, flush to 0 (all bits) and go to DONE.
  - Exit to DONE when normalised.
- DONE:
  - out_valid=1 and result stays stable until out_ready.
  - On out_valid&&out_ready, go to IDLE with out_valid=0 in the next cycle. No same-cycle re-accept.
  - result holds its last value while in IDLE.
- Latency: with the accept edge as cycle 0, out_valid rises in cycle 3+|d|+n, where n = number of NORM cycles. The zero-operand shortcut rises in cycle 2.
- Inputs are ignored while busy. in_valid held high during busy is not consumed until IDLE.

Test Plan:
- Equal exponents with carry: a=0x38, b=0x38 (1.5+1.5) -> result=0x48, out_valid in cycle 4 (d=0, n=1).
- Alignment and swap:
  - a=0x50, b=0x30 -> 0x54, out_valid in cycle 5.
  - a=0x30, b=0x50 -> 0x54, same latency.
- Cancellation and left-normalise:
  - a=0x38, b=0xB8 -> 0x00 (cycle 3).
  - a=0x3C, b=0xB8 -> 0x10 (n=2, cycle 5).
- Overflow and underflow:
  - a=0x7F, b=0x7F -> 0x7F saturated.
  - a=0x1C, b=0x98 -> 0x00 flushed.
- Zero operand and backpressure: a=0x00, b=0xC5 -> 0xC5 in cycle 2. With out_ready held low 5 cycles: result stable, in_ready=0, busy=1; IDLE is reached the cycle after out_ready=1.
- Reset mid-op: a=0x70, b=0x10 (d=6), drop rst_n during ALIGN -> out_valid=0 and in_ready=1 immediately; a new request after release returns the correct sum with nominal latency.

Source files
------------

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle minifloat adder sequencer, one shift per cycle
module fp_add_seq #(
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   busy
);

  localparam int W  = 1 + EXP_W + MAN_W;  // packed operand width
  localparam int SW = MAN_W + 1;          // significand with hidden bit
  localparam int UW = MAN_W + 2;          // sum with carry bit

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXP,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      a_r, a_nxt, b_r, b_nxt;
  logic              sign_r, sign_nxt;
  logic              sub_r, sub_nxt;
  logic [EXP_W-1:0]  exp_r, exp_nxt;
  logic [EXP_W-1:0]  cnt_r, cnt_nxt;
  logic [SW-1:0]     big_r, big_nxt;
  logic [SW-1:0]     small_r, small_nxt;
  logic [UW-1:0]     sum_r, sum_nxt;
  logic [W-1:0]      res_r, res_nxt;

  // Operand field views of the captured operands
  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  fa, fb;
  assign sa = a_r[W-1];
  assign sb = b_r[W-1];
  assign ea = a_r[W-2:MAN_W];
  assign eb = b_r[W-2:MAN_W];
  assign fa = a_r[MAN_W-1:0];
  assign fb = b_r[MAN_W-1:0];

  // Working values for the combinational step logic
  logic [EXP_W:0]    diff;
  logic [EXP_W-1:0]  mag;
  logic              a_big;
  logic [UW-1:0]     sum_c;
  logic [UW-1:0]     shl;
  logic [EXP_W-1:0]  exp_dec;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_r;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath registers follow the values chosen by the step logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sign_r  <= 1'b0;
      sub_r   <= 1'b0;
      exp_r   <= '0;
      cnt_r   <= '0;
      big_r   <= '0;
      small_r <= '0;
      sum_r   <= '0;
      res_r   <= '0;
    end else begin
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      sign_r  <= sign_nxt;
      sub_r   <= sub_nxt;
      exp_r   <= exp_nxt;
      cnt_r   <= cnt_nxt;
      big_r   <= big_nxt;
      small_r <= small_nxt;
      sum_r   <= sum_nxt;
      res_r   <= res_nxt;
    end
  end

  // Next-state and datapath step for the current state
  always_comb begin
    state_nxt = state;
    a_nxt     = a_r;
    b_nxt     = b_r;
    sign_nxt  = sign_r;
    sub_nxt   = sub_r;
    exp_nxt   = exp_r;
    cnt_nxt   = cnt_r;
    big_nxt   = big_r;
    small_nxt = small_r;
    sum_nxt   = sum_r;
    res_nxt   = res_r;
    // Exponent difference as a - b with carry-in 1, one guard bit for sign
    diff      = {1'b0, ea} + ~{1'b0, eb} + {{EXP_W{1'b0}}, 1'b1};
    mag       = diff[EXP_W] ? (~diff[EXP_W-1:0] + 1'b1) : diff[EXP_W-1:0];
    a_big     = ({ea, fa} >= {eb, fb});
    sum_c     = sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                      : ({1'b0, big_r} + {1'b0, small_r});
    shl       = sum_r << 1;
    exp_dec   = exp_r - 1'b1;

    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_nxt     = op_a;
          b_nxt     = op_b;
          state_nxt = S_EXP;
        end
      end

      S_EXP: begin
        if (ea == '0 || eb == '0) begin
          // A zero operand passes the other one through; two zeros give +0
          if (ea == '0 && eb == '0) res_nxt = '0;
          else if (ea == '0)        res_nxt = b_r;
          else                      res_nxt = a_r;
          state_nxt = S_DONE;
        end else begin
          sign_nxt  = a_big ? sa : sb;
          exp_nxt   = a_big ? ea : eb;
          big_nxt   = a_big ? {1'b1, fa} : {1'b1, fb};
          small_nxt = a_big ? {1'b1, fb} : {1'b1, fa};
          sub_nxt   = sa ^ sb;
          cnt_nxt   = mag;
          state_nxt = (mag != '0) ? S_ALIGN : S_ADD;
        end
      end

      S_ALIGN: begin
        // Truncating right shift; long shifts still spend the full count
        small_nxt = small_r >> 1;
        cnt_nxt   = cnt_r - 1'b1;
        if (cnt_r == {{(EXP_W-1){1'b0}}, 1'b1}) state_nxt = S_ADD;
      end

      S_ADD: begin
        sum_nxt = sum_c;
        if (sum_c == '0) begin
          res_nxt   = '0;
          state_nxt = S_DONE;
        end else if (sum_c[UW-1] || !sum_c[MAN_W]) begin
          state_nxt = S_NORM;
        end else begin
          res_nxt   = {sign_r, exp_r, sum_c[MAN_W-1:0]};
          state_nxt = S_DONE;
        end
      end

      S_NORM: begin
        if (sum_r[UW-1]) begin
          // Carry out: one right shift, saturating at the top exponent
          if (exp_r == {EXP_W{1'b1}})
            res_nxt = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
          else
            res_nxt = {sign_r, exp_r + 1'b1, sum_r[MAN_W:1]};
          state_nxt = S_DONE;
        end else if (exp_dec == '0) begin
          // Underflow below the smallest exponent flushes to +0
          res_nxt   = '0;
          state_nxt = S_DONE;
        end else if (shl[MAN_W]) begin
          res_nxt   = {sign_r, exp_dec, shl[MAN_W-1:0]};
          state_nxt = S_DONE;
        end else begin
          sum_nxt = shl;
          exp_nxt = exp_dec;
        end
      end

      S_DONE: begin
        if (out_ready) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// tb/tb_fp_add_seq.sv - directed self-checking bench for fp_add_seq
module tb_fp_add_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = 8'h00;
  logic [7:0] op_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       busy;

  int checks = 0;
  int failures = 0;

  fp_add_seq #(.EXP_W(3), .MAN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One transaction; latency counts cycles with the cycle after the accept edge as 1
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input int exp_cyc, input int hold);
    int cyc;
    logic [7:0] r;
    @(negedge clk);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = 8'hFF;
    op_b = 8'hFF;
    cyc = 1;
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    r = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_result"}, 32'(result), 32'(r));
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_result"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run_op("carry",  8'h38, 8'h38, 8'h48, 4, 0);
    run_op("negsum", 8'hB8, 8'hB8, 8'hC8, 4, 0);
    run_op("align",  8'h50, 8'h30, 8'h54, 5, 0);
    run_op("swap",   8'h30, 8'h50, 8'h54, 5, 0);
    run_op("cancel", 8'h38, 8'hB8, 8'h00, 3, 0);
    run_op("lnorm",  8'h3C, 8'hB8, 8'h10, 5, 0);
    run_op("ovf",    8'h7F, 8'h7F, 8'h7F, 4, 0);
    run_op("unf",    8'h1C, 8'h98, 8'h00, 4, 0);
    run_op("zero",   8'h00, 8'hC5, 8'hC5, 2, 5);

    // Abort an operation while it is aligning
    @(negedge clk);
    op_a = 8'h70;
    op_b = 8'h10;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_result", 32'(out_valid), 32'd0);

    run_op("after_rst", 8'h70, 8'h10, 8'h70, 9, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
